nco_quad: RTL and testbench

NCO_QUAD -- requirements
Module: nco_quad

---
 rtl/nco_quad_if.sv | 30 +++
 rtl/nco_quad.sv | 157 +++++++++++++++
 tb/tb_nco_quad.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/nco_quad_if.sv
// nco_quad control/sample bundle.
// master drives controls, slave returns samples.
interface nco_quad_if #(
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 16
);
  logic                      en;
  logic [PHASE_W-1:0]        freq_word;
  logic                      freq_ld;
  logic [PHASE_W-1:0]        phase_off;
  logic                      sync_clr;
  logic signed [OUT_W-1:0]   sin_out;
  logic signed [OUT_W-1:0]   cos_out;
  logic                      out_valid;
  logic                      wrap;

  modport master (
    output en, freq_word, freq_ld,
    output phase_off, sync_clr,
    input  sin_out, cos_out,
    input  out_valid, wrap
  );

  modport slave (
    input  en, freq_word, freq_ld,
    input  phase_off, sync_clr,
    output sin_out, cos_out,
    output out_valid, wrap
  );
endinterface

// File: rtl/nco_quad.sv
// Quadrature NCO: 3-stage accumulator/quarter-wave ROM pipeline.
// Optional phase dither under macro NCO_DITHER_EN.
module nco_quad #(
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 10,
  parameter int OUT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  nco_quad_if.slave   bus
);
  localparam int IW = LUT_AW - 2;
  localparam int N  = 2 ** IW;
  localparam real PI = 3.141592653589793;
  localparam logic [OUT_W-2:0] FULL = '1;

  function automatic logic [OUT_W-2:0] rom_val(
    input int k
  );
    real x;
    x = real'((2 ** (OUT_W - 1)) - 1)
      * $sin(2.0 * PI * real'(k) / real'(4 * N));
    return (OUT_W-1)'($rtoi(x + 0.5));
  endfunction

  logic [OUT_W-2:0] w_rom [N];
  for (genvar k = 0; k < N; k++) begin : g_rom
    assign w_rom[k] = rom_val(k);
  end

  logic [PHASE_W-1:0] r_acc;
  logic [PHASE_W-1:0] r_fw;
  logic [PHASE_W:0]   w_sum;
  logic [LUT_AW-1:0]  w_a;
  logic [LUT_AW-1:0]  r_a;
  logic               r_v1;
  logic               r_w1;

  assign w_sum = {1'b0, r_acc} + {1'b0, r_fw};

`ifdef NCO_DITHER_EN
  localparam int DW = PHASE_W - LUT_AW;
  logic [15:0]        r_lfsr;
  logic [PHASE_W-1:0] w_dith;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= 16'hACE1;
    end else if (bus.en) begin
      r_lfsr <= {r_lfsr[14:0],
                 r_lfsr[15] ^ r_lfsr[13]
               ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  // LFSR MSB lines up with the top sub-address bit
  if (DW == 0) begin : g_nodith
    assign w_dith = '0;
  end else if (DW >= 16) begin : g_wide
    assign w_dith = PHASE_W'(r_lfsr) << (DW - 16);
  end else begin : g_narrow
    assign w_dith = PHASE_W'(r_lfsr >> (16 - DW));
  end

  assign w_a = LUT_AW'((r_acc + bus.phase_off + w_dith)
             >> (PHASE_W - LUT_AW));
`else
  assign w_a = LUT_AW'((r_acc + bus.phase_off)
             >> (PHASE_W - LUT_AW));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_fw  <= '0;
      r_a   <= '0;
      r_v1  <= 1'b0;
      r_w1  <= 1'b0;
    end else begin
      if (bus.freq_ld) r_fw <= bus.freq_word;
      if (bus.sync_clr) begin
        r_acc <= '0;
      end else if (bus.en) begin
        r_acc <= w_sum[PHASE_W-1:0];
      end
      if (bus.en) begin
        r_a  <= w_a;
        r_w1 <= w_sum[PHASE_W];
      end
      r_v1 <= bus.en;
    end
  end

  // cosine leads sine by one quadrant
  logic [LUT_AW-1:0] w_ac;
  logic [IW-1:0]     w_is;
  logic [IW-1:0]     w_ic;
  logic [IW-1:0]     w_xs;
  logic [IW-1:0]     w_xc;
  logic              w_zs;
  logic              w_zc;

  assign w_ac = r_a + LUT_AW'(N);
  assign w_is = r_a[IW-1:0];
  assign w_ic = w_ac[IW-1:0];
  assign w_xs = r_a[IW]  ? (~w_is + 1'b1) : w_is;
  assign w_xc = w_ac[IW] ? (~w_ic + 1'b1) : w_ic;
  assign w_zs = r_a[IW]  && (w_is == '0);
  assign w_zc = w_ac[IW] && (w_ic == '0);

  logic [OUT_W-2:0] r_ms;
  logic [OUT_W-2:0] r_mc;
  logic             r_ns;
  logic             r_nc;
  logic             r_v2;
  logic             r_w2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ms <= '0;
      r_mc <= '0;
      r_ns <= 1'b0;
      r_nc <= 1'b0;
      r_v2 <= 1'b0;
      r_w2 <= 1'b0;
    end else begin
      r_ms <= w_zs ? FULL : w_rom[w_xs];
      r_mc <= w_zc ? FULL : w_rom[w_xc];
      r_ns <= r_a[IW+1];
      r_nc <= w_ac[IW+1];
      r_v2 <= r_v1;
      r_w2 <= r_v1 & r_w1;
    end
  end

  logic [OUT_W-1:0] w_ps;
  logic [OUT_W-1:0] w_pc;

  assign w_ps = {1'b0, r_ms};
  assign w_pc = {1'b0, r_mc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.sin_out   <= '0;
      bus.cos_out   <= '0;
      bus.out_valid <= 1'b0;
      bus.wrap      <= 1'b0;
    end else begin
      if (r_v2) begin
        bus.sin_out <= r_ns ? -w_ps : w_ps;
        bus.cos_out <= r_nc ? -w_pc : w_pc;
      end
      bus.out_valid <= r_v2;
      bus.wrap      <= r_v2 & r_w2;
    end
  end
endmodule

// File: tb/tb_nco_quad.sv
// Directed bench for nco_quad (default build).
// Row table: inputs per cycle, expected output 3 cycles on.
module tb_nco_quad;
  localparam real PI = 3.141592653589793;

  logic clk;
  logic rst;

  nco_quad_if #(.PHASE_W(32), .OUT_W(16)) bus_if ();

  nco_quad #(
    .PHASE_W (32),
    .LUT_AW  (10),
    .OUT_W   (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          en;
    bit          clr;
    bit          ld;
    logic [31:0] fw;
    logic [31:0] off;
    bit          v;
    bit          w;
    int          s;
    int          c;
  } row_t;

  row_t  rows[$];
  int    last_s;
  int    last_c;
  int    n_tot;
  int    n_bad;
  string cur;

  task automatic chk(
    input string              tag,
    input logic signed [31:0] got,
    input logic signed [31:0] exp
  );
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d",
               tag, got, exp);
    end
  endtask

  function automatic int ref_sin(input int a);
    real v;
    v = 32767.0 * $sin(2.0 * PI
      * real'(a & 1023) / 1024.0);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  task automatic add_row(
    input bit          en,
    input bit          clr,
    input bit          ld,
    input logic [31:0] fw,
    input logic [31:0] off,
    input bit          w,
    input logic [31:0] ph
  );
    row_t r;
    int   a;
    a = int'(ph[31:22]);
    r.en = en; r.clr = clr; r.ld = ld;
    r.fw = fw; r.off = off;
    r.v = en;
    r.w = en & w;
    if (en) begin
      last_s = ref_sin(a);
      last_c = ref_sin(a + 256);
    end
    r.s = last_s;
    r.c = last_c;
    rows.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input row_t r);
    bus_if.en        = r.en;
    bus_if.sync_clr  = r.clr;
    bus_if.freq_ld   = r.ld;
    bus_if.freq_word = r.fw;
    bus_if.phase_off = r.off;
  endtask

  task automatic idle();
    bus_if.en        = 1'b0;
    bus_if.sync_clr  = 1'b0;
    bus_if.freq_ld   = 1'b0;
    bus_if.freq_word = '0;
    bus_if.phase_off = '0;
  endtask

  task automatic run_rows();
    int   l;
    row_t e;
    l = rows.size();
    for (int t = 0; t < l + 2; t++) begin
      if (t < l) drive(rows[t]);
      else idle();
      tick();
      if (t >= 2) begin
        e = rows[t-2];
        chk($sformatf("%s.valid[%0d]", cur, t-2),
            bus_if.out_valid, e.v);
        chk($sformatf("%s.sin[%0d]", cur, t-2),
            bus_if.sin_out, e.s);
        chk($sformatf("%s.cos[%0d]", cur, t-2),
            bus_if.cos_out, e.c);
        chk($sformatf("%s.wrap[%0d]", cur, t-2),
            bus_if.wrap, e.w);
      end
    end
    rows.delete();
  endtask

  task automatic add_quarter(input int n);
    add_row(0, 1, 1, 32'h4000_0000, 0, 0, 0);
    for (int k = 0; k < n; k++)
      add_row(1, 0, 0, 0, 0, (k % 4) == 3,
              32'(k) << 30);
  endtask

  task automatic rand_in();
    bus_if.en        = 1'($urandom);
    bus_if.sync_clr  = 1'($urandom);
    bus_if.freq_ld   = 1'($urandom);
    bus_if.freq_word = $urandom;
    bus_if.phase_off = $urandom;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".sin"},   bus_if.sin_out,   0);
    chk({tag, ".cos"},   bus_if.cos_out,   0);
    chk({tag, ".valid"}, bus_if.out_valid, 0);
    chk({tag, ".wrap"},  bus_if.wrap,      0);
  endtask

  initial begin
    n_tot  = 0;
    n_bad  = 0;
    last_s = 0;
    last_c = 0;
    rst    = 1'b1;
    idle();

    #3;
    rand_in();
    rst = 1'b0;
    #1;
    chk_zero("reset");
    tick();
    tick();
    rst = 1'b1;
    idle();

    cur = "quarter";
    add_quarter(12);
    run_rows();

    cur = "offset";
    add_row(0, 1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      add_row(1, 0, 0, 0, 32'h4000_0000, 0,
              32'h4000_0000);
    for (int k = 0; k < 4; k++)
      add_row(1, 0, 0, 0, 32'h8000_0000, 0,
              32'h8000_0000);
    run_rows();

    cur = "clrld";
    add_row(0, 1, 1, 32'h4000_0000, 0, 0, 0);
    add_row(1, 0, 0, 0, 0, 0, 32'h0000_0000);
    add_row(1, 0, 0, 0, 0, 0, 32'h4000_0000);
    add_row(1, 1, 1, 32'h0040_0000, 0, 0,
            32'h8000_0000);
    add_row(0, 0, 0, 0, 0, 0, 0);
    add_row(1, 0, 0, 0, 0, 0, 32'h0000_0000);
    add_row(1, 0, 0, 0, 0, 0, 32'h0040_0000);
    add_row(1, 0, 0, 0, 0, 0, 32'h0080_0000);
    run_rows();

    cur = "fine";
    add_row(0, 1, 1, 32'h0040_0000, 0, 0, 0);
    for (int k = 0; k < 1030; k++)
      add_row(1, 0, 0, 0, 0, (k % 1024) == 1023,
              32'(k) << 22);
    run_rows();

    cur = "prerst";
    add_quarter(5);
    run_rows();
    bus_if.en = 1'b1;
    tick();
    tick();
    #2;
    rand_in();
    rst = 1'b0;
    #1;
    chk_zero("midrst");
    tick();
    rst = 1'b1;
    idle();
    last_s = 0;
    last_c = 0;
    cur = "postrst";
    add_quarter(8);
    run_rows();

    $display("test done: total=%0d bad=%0d",
             n_tot, n_bad);
    $finish;
  end
endmodule
